// File: rtl/isqrt_seq_fsm.sv
// Sequential restoring integer square root: y = floor(sqrt(x)), one result bit per clock.
// Valid-only handshake; a new operand is accepted in idle or in the result cycle.
module isqrt_seq_fsm #(
    parameter int X_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [X_W-1:0]   x,
    output logic             y_vld,
    output logic [X_W/2-1:0] y
);

    localparam int Y_W   = X_W / 2;
    localparam int CNT_W = (Y_W > 1) ? $clog2(Y_W) : 1;
    localparam logic [X_W-1:0]   ONE_INIT = {{(X_W-1){1'b0}}, 1'b1} << (X_W - 2);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(Y_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [X_W-1:0]   op;
    logic [X_W-1:0]   res;
    logic [X_W-1:0]   one;

    logic [X_W-1:0]   trial;
    logic [X_W-1:0]   op_step;
    logic [X_W-1:0]   res_step;

    // One restoring step: subtract the trial value when it fits and set that result bit.
    always_comb begin
        trial    = res + one;
        op_step  = op;
        res_step = res >> 1;
        if (op >= trial) begin
            op_step  = op - trial;
            res_step = (res >> 1) + one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op    <= '0;
            res   <= '0;
            one   <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    y_vld <= 1'b0;
                    if (x_vld) begin
                        op    <= x;
                        res   <= '0;
                        one   <= ONE_INIT;
                        cnt   <= CNT_INIT;
                        state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    op  <= op_step;
                    res <= res_step;
                    one <= one >> 2;
                    if (cnt == '0) begin
                        y     <= res_step[Y_W-1:0];
                        y_vld <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // The result cycle doubles as an accept slot so initiators see no bubble.
                    y_vld <= 1'b0;
                    if (x_vld) begin
                        op    <= x;
                        res   <= '0;
                        one   <= ONE_INIT;
                        cnt   <= CNT_INIT;
                        state <= ST_ITER;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    y_vld <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq_fsm.sv
// Directed and randomized bench for isqrt_seq_fsm (X_W = 32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_isqrt_seq_fsm;

    localparam int X_W = 32;
    localparam int Y_W = 16;
    localparam int LAT = Y_W;  // edges from accept edge to the edge that raises y_vld

    logic           clk = 1'b0;
    logic           rst;
    logic           x_vld;
    logic [X_W-1:0] x;
    logic           y_vld;
    logic [Y_W-1:0] y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } vec_t;

    vec_t vecs[12];

    isqrt_seq_fsm #(.X_W(X_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for y_vld; returns number of edges waited and whether it arrived.
    task automatic wait_result(input int start_lat, output int lat, output bit got);
        lat = start_lat;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (y_vld) got = 1'b1;
        end
    endtask

    task automatic run_one(input string name, input logic [X_W-1:0] xv, input logic [Y_W-1:0] exp);
        int lat;
        bit got;
        x_vld = 1'b1;
        x     = xv;
        tick();
        x_vld = 1'b0;
        x     = $urandom;  // operand must already be captured
        wait_result(0, lat, got);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no y_vld within 40 cycles, expected y=%0d", name, exp);
        end else begin
            check({name, " y"}, 64'(y), 64'(exp));
            check({name, " latency"}, 64'(lat), 64'(LAT));
            tick();
            check({name, " pulse width"}, 64'(y_vld), 64'd0);
        end
    endtask

    function automatic logic [Y_W-1:0] ref_sqrt(input logic [X_W-1:0] v);
        logic [63:0] lo, hi, mid;
        lo = 0;
        hi = 64'hFFFF;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= 64'(v)) lo = mid;
            else hi = mid - 1;
        end
        return lo[Y_W-1:0];
    endfunction

    initial begin
        int lat;
        bit got;
        int pulses;
        logic [X_W-1:0] rx;
        logic [31:0] k;

        vecs[0]  = '{32'd0,          16'd0};
        vecs[1]  = '{32'd1,          16'd1};
        vecs[2]  = '{32'd2,          16'd1};
        vecs[3]  = '{32'd3,          16'd1};
        vecs[4]  = '{32'd4,          16'd2};
        vecs[5]  = '{32'd99,         16'd9};
        vecs[6]  = '{32'd100,        16'd10};
        vecs[7]  = '{32'hFFFF_FFFF,  16'hFFFF};
        vecs[8]  = '{32'hFFFE_0001,  16'hFFFF};
        vecs[9]  = '{32'hFFFE_0000,  16'hFFFE};
        vecs[10] = '{32'd65535,      16'd255};
        vecs[11] = '{32'd65536,      16'd256};

        rst   = 1'b1;
        x_vld = 1'b0;
        x     = '0;
        repeat (3) tick();
        check("reset y_vld", 64'(y_vld), 64'd0);
        check("reset y", 64'(y), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].y);
        end

        // Back-to-back: second operand offered in the y_vld cycle.
        x_vld = 1'b1;
        x     = 32'd144;
        tick();
        x_vld = 1'b0;
        wait_result(0, lat, got);
        check("b2b first arrived", 64'(got), 64'd1);
        check("b2b first y", 64'(y), 64'd12);
        x_vld = 1'b1;
        x     = 32'd169;
        tick();
        x_vld = 1'b0;
        check("b2b gap y_vld", 64'(y_vld), 64'd0);
        wait_result(0, lat, got);
        check("b2b second arrived", 64'(got), 64'd1);
        check("b2b second y", 64'(y), 64'd13);
        check("b2b second latency", 64'(lat), 64'(LAT));
        tick();

        // Operand offered mid-computation must be dropped.
        x_vld = 1'b1;
        x     = 32'd81;
        tick();
        x_vld = 1'b0;
        repeat (4) tick();
        x_vld = 1'b1;
        x     = 32'd400;
        tick();
        x_vld = 1'b0;
        wait_result(5, lat, got);
        check("drop arrived", 64'(got), 64'd1);
        check("drop y", 64'(y), 64'd9);
        check("drop latency", 64'(lat), 64'(LAT));
        pulses = 0;
        repeat (30) begin
            tick();
            if (y_vld) pulses++;
        end
        check("drop no second y_vld", 64'(pulses), 64'd0);

        // Reset in the middle of a computation.
        x_vld = 1'b1;
        x     = 32'd10000;
        tick();
        x_vld = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset y_vld", 64'(y_vld), 64'd0);
        check("midreset y", 64'(y), 64'd0);
        pulses = 0;
        repeat (20) begin
            tick();
            if (y_vld) pulses++;
        end
        check("midreset no y_vld", 64'(pulses), 64'd0);
        run_one("after reset", 32'd49, 16'd7);

        // Randomized operands including perfect squares and their predecessors.
        for (int i = 0; i < 1000; i++) begin
            k = 32'($urandom_range(1, 65535));
            case (i % 3)
                0: rx = k * k;
                1: rx = k * k - 1;
                default: rx = $urandom;
            endcase
            run_one($sformatf("rand%0d x=%0d", i, rx), rx, ref_sqrt(rx));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
